bn_fifo_reader: RTL and testbench

- Consumer-side controller for the batch-norm FIFO path.
- Issues rd_en toward the BN FIFO. Sees the FIFO's data, empty/full flags and BN parameters only after the one-cycle pipeline register stage, so it tracks in-flight reads across that latency.
- Applies y = (x - mean) * inv_std * gamma + beta in fixed point.
- Delivers results on a valid/ready stream through an internal skid buffer, so downstream backpressure never loses a read word.

---
 rtl/bn_pkg.sv | 23 ++
 rtl/bn_skid_fifo.sv | 37 +++
 rtl/bn_fifo_reader.sv | 77 +++++++
 tb/tb_bn_fifo_reader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bn_pkg.sv
// bn_pkg: shared sample types, saturation limits and helpers for the batch-norm reader.
package bn_pkg;
  localparam int DW_DEF = 16;
  localparam int FRAC_DEF = 8;
  localparam int WIDE = 2 * DW_DEF + 2;
  typedef logic signed [DW_DEF-1:0] sample_t;
  typedef logic signed [WIDE-1:0] wide_t;
  typedef struct packed {
    logic    sat;
    sample_t val;
  } sat_t;
  localparam sample_t SAT_MAX = {1'b0, {(DW_DEF-1){1'b1}}};
  localparam sample_t SAT_MIN = {1'b1, {(DW_DEF-1){1'b0}}};
  function automatic wide_t sx(input sample_t v);
    return {{(WIDE-DW_DEF){v[DW_DEF-1]}}, v};
  endfunction
  function automatic sat_t saturate(input wide_t v);
    sat_t r;
    r.sat = (v > sx(SAT_MAX)) || (v < sx(SAT_MIN));
    r.val = v > sx(SAT_MAX) ? SAT_MAX : v < sx(SAT_MIN) ? SAT_MIN : v[DW_DEF-1:0];
    return r;
  endfunction
endpackage

// File: rtl/bn_skid_fifo.sv
// bn_skid_fifo: circular output buffer with occupancy count; head reads as zero when empty.
module bn_skid_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic pop_e;
  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
  assign pop_e = pop & ~empty;
  assign rdata = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (pop_e) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop_e);
    end
endmodule

// File: rtl/bn_fifo_reader.sv
// bn_fifo_reader: paces reads from the BN FIFO, normalises each word in two stages
// and queues results in a skid buffer sized so backpressure never drops a word.
module bn_fifo_reader import bn_pkg::*; #(
  parameter int DATA_WIDTH = DW_DEF,
  parameter int FRAC_BITS  = FRAC_DEF,
  parameter int RD_LATENCY = 2,
  parameter int FLAG_LAG   = 1,
  parameter int SKID_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bn_en,
  input  logic                  bn_fifo_empty,
  input  logic                  bn_fifo_full,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] bn_mean,
  input  logic [DATA_WIDTH-1:0] bn_std,
  input  logic [DATA_WIDTH-1:0] bn_gamma,
  input  logic [DATA_WIDTH-1:0] bn_beta,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  idle,
  output logic                  sat_flag
);
  localparam int CW = $clog2(SKID_DEPTH + 1);
  logic [RD_LATENCY-1:0] tok;
  logic [3:0] guard;
  logic [7:0] inflight;
  logic issue, cap, pop, skid_full, skid_empty, s1_v, s2_v;
  logic [CW-1:0] skid_count;
  sample_t s1_p, s1_gamma, s1_beta, s2_y;
  sat_t r1, r2;
  assign cap = tok[RD_LATENCY-1];
  assign pop = out_valid & out_ready;
  assign out_valid = ~skid_empty;
  assign idle = ~rd_en & ~|tok & ~s1_v & ~s2_v & skid_empty;
  assign r1 = saturate(((sx(data_in) - sx(bn_mean)) * sx(bn_std)) >>> FRAC_BITS);
  assign r2 = saturate(((sx(s1_p) * sx(s1_gamma)) >>> FRAC_BITS) + sx(s1_beta));
  // Everything already committed to land in the skid: pending rd_en, tokens, compute stages.
  always_comb begin
    inflight = 8'(rd_en) + 8'(s1_v) + 8'(s2_v);
    for (int i = 0; i < RD_LATENCY; i++) inflight += 8'(tok[i]);
    issue = bn_en & ~bn_fifo_empty & (guard == '0) & (8'(skid_count) + inflight < 8'(SKID_DEPTH));
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_en    <= 1'b0;
      tok      <= '0;
      guard    <= '0;
      s1_v     <= 1'b0;
      s1_p     <= '0;
      s1_gamma <= '0;
      s1_beta  <= '0;
      s2_v     <= 1'b0;
      s2_y     <= '0;
      sat_flag <= 1'b0;
    end else begin
      rd_en    <= issue;
      tok      <= RD_LATENCY'({tok, rd_en});
      guard    <= issue ? 4'(FLAG_LAG) : guard - 4'(guard != '0);
      s1_v     <= cap;
      s1_p     <= r1.val;
      s1_gamma <= bn_gamma;
      s1_beta  <= bn_beta;
      s2_v     <= s1_v;
      s2_y     <= r2.val;
      sat_flag <= sat_flag | (cap & r1.sat) | (s1_v & r2.sat);
    end
  bn_skid_fifo #(.DEPTH(SKID_DEPTH), .WIDTH(DATA_WIDTH)) u_skid (
    .clk(clk), .rst(rst), .push(s2_v), .pop(pop), .wdata(s2_y), .rdata(out_data),
    .full(skid_full), .empty(skid_empty), .count(skid_count)
  );
  assert property (@(posedge clk) disable iff (!rst) !(skid_full && s2_v && !pop));
  assert property (@(posedge clk) disable iff (!rst) !(bn_fifo_full && bn_fifo_empty));
endmodule

// File: tb/tb_bn_fifo_reader.sv
// tb_bn_fifo_reader: directed scenarios against a bench-side FIFO with a two-cycle read path.
module tb_bn_fifo_reader;
  logic clk = 1'b0;
  logic rst, bn_en, bn_fifo_empty, bn_fifo_full, rd_en, out_valid, out_ready, idle, sat_flag;
  logic [15:0] data_in, bn_mean, bn_std, bn_gamma, bn_beta, out_data;
  logic [15:0] words [256];
  logic [15:0] pend = 16'h5A5A, mid = 16'h5A5A;
  int wr_idx = 0, rd_idx = 0, underflow = 0, cyc = 0, ov_cnt = 0;
  int rd_cyc[$], got_cyc[$];
  logic [15:0] got[$];
  int total = 0, bad = 0;

  bn_fifo_reader dut (
    .clk(clk), .rst(rst), .bn_en(bn_en), .bn_fifo_empty(bn_fifo_empty), .bn_fifo_full(bn_fifo_full),
    .data_in(data_in), .bn_mean(bn_mean), .bn_std(bn_std), .bn_gamma(bn_gamma), .bn_beta(bn_beta),
    .rd_en(rd_en), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .idle(idle), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // FIFO read registers its output, then the pipeline register adds one more cycle.
  always @(negedge clk) begin
    data_in = mid;
    mid = pend;
    pend = 16'h5A5A;
    if (rd_en) begin
      rd_cyc.push_back(cyc);
      if (rd_idx < wr_idx) begin
        pend = words[rd_idx];
        rd_idx++;
      end else underflow++;
    end
    if (out_valid) ov_cnt++;
    if (out_valid && out_ready) begin
      got.push_back(out_data);
      got_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [15:0] x, m, s, g, b, output logic [15:0] y,
                         output int lat, output int n, output int rds);
    int rb, gb;
    rb = rd_cyc.size();
    gb = got.size();
    words[wr_idx] = x;
    wr_idx++;
    bn_mean = m; bn_std = s; bn_gamma = g; bn_beta = b; out_ready = 1'b1;
    bn_fifo_empty = 1'b0;
    tick();
    tick();
    bn_fifo_empty = 1'b1;
    for (int i = 0; i < 40 && !(got.size() > gb && idle); i++) tick();
    n = got.size() - gb;
    rds = rd_cyc.size() - rb;
    y = n > 0 ? got[gb] : 16'hxxxx;
    lat = (n > 0 && rds > 0) ? got_cyc[gb] - rd_cyc[rb] : -1;
  endtask

  task automatic test_reset();
    rst = 1'b0; bn_en = 1'b1; bn_fifo_empty = 1'b1; bn_fifo_full = 1'b0; out_ready = 1'b1;
    bn_mean = '0; bn_std = '0; bn_gamma = '0; bn_beta = '0;
    repeat (3) tick();
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", rd_en); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL reset_out_data got=%h want=0000", out_data); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL reset_sat_flag got=%b want=0", sat_flag); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b want=1", idle); end
    rst = 1'b1;
    repeat (3) tick();
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL post_reset_rd_en got=%b want=0", rd_en); end
  endtask

  task automatic test_single();
    logic [15:0] y; int lat, n, rds;
    run_one(16'h0300, 16'h0100, 16'h0080, 16'h0200, 16'h0080, y, lat, n, rds);
    total++; if (y !== 16'h0280) begin bad++; $display("FAIL single_data got=%h want=0280", y); end
    total++; if (lat !== 5) begin bad++; $display("FAIL single_latency got=%0d want=5", lat); end
    total++; if (n !== 1) begin bad++; $display("FAIL single_count got=%0d want=1", n); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle got=%b want=1", idle); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL single_sat_flag got=%b want=0", sat_flag); end
  endtask

  task automatic test_stale_flag();
    logic [15:0] y; int lat, n, rds, ub;
    ub = underflow;
    run_one(16'h0100, 16'h0000, 16'h0100, 16'h0100, 16'h0000, y, lat, n, rds);
    total++; if (rds !== 1) begin bad++; $display("FAIL stale_reads got=%0d want=1", rds); end
    total++; if (underflow !== ub) begin bad++; $display("FAIL stale_underflow got=%0d want=%0d", underflow, ub); end
    total++; if (y !== 16'h0100) begin bad++; $display("FAIL stale_data got=%h want=0100", y); end
  endtask

  task automatic test_floor();
    logic [15:0] y; int lat, n, rds;
    run_one(16'hFFFF, 16'h0000, 16'h0080, 16'h0100, 16'h0000, y, lat, n, rds);
    total++; if (y !== 16'hFFFF) begin bad++; $display("FAIL floor_neg got=%h want=ffff", y); end
    run_one(16'h0001, 16'h0000, 16'h0080, 16'h0100, 16'h0000, y, lat, n, rds);
    total++; if (y !== 16'h0000) begin bad++; $display("FAIL floor_pos got=%h want=0000", y); end
  endtask

  task automatic test_saturation();
    logic [15:0] y; int lat, n, rds;
    run_one(16'h7F00, 16'h8000, 16'h0100, 16'h0100, 16'h0000, y, lat, n, rds);
    total++; if (y !== 16'h7FFF) begin bad++; $display("FAIL sat_pos got=%h want=7fff", y); end
    total++; if (sat_flag !== 1'b1) begin bad++; $display("FAIL sat_flag_set got=%b want=1", sat_flag); end
    run_one(16'h8000, 16'h7FFF, 16'h0100, 16'h0100, 16'h0000, y, lat, n, rds);
    total++; if (y !== 16'h8000) begin bad++; $display("FAIL sat_neg got=%h want=8000", y); end
    run_one(16'h4000, 16'h0000, 16'h0100, 16'h0400, 16'h0000, y, lat, n, rds);
    total++; if (y !== 16'h7FFF) begin bad++; $display("FAIL sat_stage2 got=%h want=7fff", y); end
    run_one(16'h0300, 16'h0100, 16'h0080, 16'h0200, 16'h0080, y, lat, n, rds);
    total++; if (y !== 16'h0280) begin bad++; $display("FAIL sat_then_normal got=%h want=0280", y); end
    total++; if (sat_flag !== 1'b1) begin bad++; $display("FAIL sat_flag_sticky got=%b want=1", sat_flag); end
  endtask

  // Parameters give y = 2*(x - 0x100) + 0x10 exactly.
  task automatic test_stream();
    int rb, gb, ub, errs, xi;
    rb = rd_cyc.size(); gb = got.size(); ub = underflow;
    bn_mean = 16'h0100; bn_std = 16'h0100; bn_gamma = 16'h0200; bn_beta = 16'h0010; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) words[wr_idx + i] = 16'(i * 257 - 1024);
    wr_idx += 20;
    bn_fifo_empty = 1'b0;
    for (int i = 0; i < 300 && got.size() - gb < 20; i++) begin
      if (rd_cyc.size() - rb >= 20) bn_fifo_empty = 1'b1;
      tick();
    end
    bn_fifo_empty = 1'b1;
    total++; if (got.size() - gb !== 20) begin bad++; $display("FAIL stream_count got=%0d want=20", got.size() - gb); end
    for (int i = 0; i < 20 && got.size() - gb == 20; i++) begin
      xi = i * 257 - 1024;
      total++;
      if (got[gb + i] !== 16'(2 * (xi - 256) + 16)) begin
        bad++; $display("FAIL stream_word%0d got=%h want=%h", i, got[gb + i], 16'(2 * (xi - 256) + 16));
      end
    end
    total++; if (rd_cyc.size() - rb !== 20) begin bad++; $display("FAIL stream_reads got=%0d want=20", rd_cyc.size() - rb); end
    errs = 0;
    for (int i = 1; i < 20 && rd_cyc.size() - rb >= 20; i++) if (rd_cyc[rb + i] - rd_cyc[rb + i - 1] != 2) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL stream_spacing bad_gaps=%0d want=0", errs); end
    total++; if (underflow !== ub) begin bad++; $display("FAIL stream_underflow got=%0d want=%0d", underflow, ub); end
  endtask

  task automatic test_backpressure();
    int rb, gb, errs, xi;
    rb = rd_cyc.size(); gb = got.size();
    bn_mean = 16'h0100; bn_std = 16'h0100; bn_gamma = 16'h0200; bn_beta = 16'h0010; out_ready = 1'b0;
    for (int i = 0; i < 12; i++) words[wr_idx + i] = 16'(512 + i * 273);
    wr_idx += 12;
    bn_fifo_empty = 1'b0;
    repeat (40) tick();
    total++; if (rd_cyc.size() - rb !== 8) begin bad++; $display("FAIL bp_reads_held got=%0d want=8", rd_cyc.size() - rb); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid got=%b want=1", out_valid); end
    total++; if (out_data !== 16'(2 * (512 - 256) + 16)) begin bad++; $display("FAIL bp_head got=%h want=%h", out_data, 16'(2 * (512 - 256) + 16)); end
    total++; if (got.size() - gb !== 0) begin bad++; $display("FAIL bp_no_pop got=%0d want=0", got.size() - gb); end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL bp_idle got=%b want=0", idle); end
    out_ready = 1'b1;
    for (int i = 0; i < 300 && got.size() - gb < 12; i++) begin
      if (rd_cyc.size() - rb >= 12) bn_fifo_empty = 1'b1;
      tick();
    end
    bn_fifo_empty = 1'b1;
    total++; if (got.size() - gb !== 12) begin bad++; $display("FAIL bp_drain_count got=%0d want=12", got.size() - gb); end
    errs = 0;
    for (int i = 0; i < 12 && got.size() - gb == 12; i++) begin
      xi = 512 + i * 273;
      if (got[gb + i] !== 16'(2 * (xi - 256) + 16)) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL bp_order wrong_words=%0d want=0", errs); end
    total++; if (rd_cyc.size() - rb !== 12) begin bad++; $display("FAIL bp_reads_total got=%0d want=12", rd_cyc.size() - rb); end
  endtask

  // Reset lands with three results buffered and later reads still in the pipe.
  task automatic test_async_reset();
    int rb, ob;
    rb = rd_cyc.size();
    bn_mean = 16'h0100; bn_std = 16'h0100; bn_gamma = 16'h0200; bn_beta = 16'h0010; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) words[wr_idx + i] = 16'(768 + i * 16);
    wr_idx += 10;
    bn_fifo_empty = 1'b0;
    for (int i = 0; i < 10 && rd_cyc.size() == rb; i++) tick();
    for (int i = 0; i < 20 && rd_cyc.size() > rb && cyc < rd_cyc[rb] + 9; i++) tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_valid got=%b want=1", out_valid); end
    rst = 1'b0;
    #1;
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL ar_rd_en got=%b want=0", rd_en); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL ar_out_data got=%h want=0000", out_data); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL ar_idle got=%b want=1", idle); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL ar_sat_flag got=%b want=0", sat_flag); end
    bn_fifo_empty = 1'b1;
    out_ready = 1'b1;
    #2;
    rst = 1'b1;
    ob = ov_cnt;
    repeat (15) tick();
    total++; if (ov_cnt !== ob) begin bad++; $display("FAIL ar_stale_valid got=%0d want=%0d", ov_cnt, ob); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL ar_idle_after got=%b want=1", idle); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stale_flag();
    test_floor();
    test_saturation();
    test_stream();
    test_backpressure();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
